// File: rtl/race_progress_tracker.sv
// Per-frame race kinematics: pedal/crash inputs -> speed, accumulated distance, race phase.
// Updates land on the clk edge carrying frame_start; no backpressure, outputs simply hold between frames.
module race_progress_tracker #(
  parameter int FINISH_DISTANCE = 10700,
  parameter int MAX_SPEED       = 16,
  parameter int ACCEL_FRAMES    = 4,
  parameter int BRAKE_STEP      = 2,
  parameter int CRASH_FRAMES    = 60
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        frame_start,
  input  logic        accelerate,
  input  logic        brake,
  input  logic        crash,
  output logic [31:0] distance_drove,
  output logic [4:0]  speed,
  output logic [1:0]  race_state,
  output logic        race_finished
);

  localparam int STEP_W  = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
  localparam int CRASH_W = (CRASH_FRAMES > 1) ? $clog2(CRASH_FRAMES) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RACING   = 2'd1,
    CRASHED  = 2'd2,
    FINISHED = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          dist_q, dist_d;
  logic [4:0]           speed_q, speed_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic [CRASH_W-1:0]   crash_cnt_q, crash_cnt_d;
  logic                 crash_latch_q, crash_latch_d;

  logic [32:0] dist_sum;
  logic [31:0] new_dist;
  logic        crash_seen;
  logic        step_wrap;

  // A crash arriving on the frame_start cycle itself still counts for that frame.
  assign crash_seen = crash_latch_q | crash;
  assign dist_sum   = {1'b0, dist_q} + {28'd0, speed_q};
  assign new_dist   = (dist_sum > 33'h0_7FFF_FFFF) ? 32'h7FFF_FFFF : dist_sum[31:0];
  assign step_wrap  = (step_q == STEP_W'(ACCEL_FRAMES - 1));

  always_comb begin
    state_d       = state_q;
    dist_d        = dist_q;
    speed_d       = speed_q;
    step_d        = step_q;
    crash_cnt_d   = crash_cnt_q;
    crash_latch_d = frame_start ? 1'b0 : (crash_latch_q | crash);

    if (frame_start) begin
      case (state_q)
        IDLE: begin
          if (accelerate) begin
            state_d = RACING;
            speed_d = 5'd0;
            step_d  = '0;
          end
        end
        RACING: begin
          dist_d = new_dist;
          if (new_dist >= 32'(FINISH_DISTANCE)) begin
            speed_d = 5'd0;
            state_d = FINISHED;
          end else if (crash_seen) begin
            speed_d     = 5'd0;
            crash_cnt_d = CRASH_W'(CRASH_FRAMES - 1);
            step_d      = '0;
            state_d     = CRASHED;
          end else if (brake) begin
            speed_d = (speed_q > 5'(BRAKE_STEP)) ? speed_q - 5'(BRAKE_STEP) : 5'd0;
            step_d  = '0;
          end else if (step_wrap) begin
            step_d = '0;
            if (accelerate)
              speed_d = (speed_q >= 5'(MAX_SPEED)) ? 5'(MAX_SPEED) : speed_q + 5'd1;
            else
              speed_d = (speed_q == 5'd0) ? 5'd0 : speed_q - 5'd1;
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
        CRASHED: begin
          // Latched crashes are dropped here, so a second hit never extends the hold.
          if (crash_cnt_q == '0)
            state_d = RACING;
          else
            crash_cnt_d = crash_cnt_q - CRASH_W'(1);
        end
        FINISHED: begin
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      state_q       <= IDLE;
      dist_q        <= 32'd0;
      speed_q       <= 5'd0;
      step_q        <= '0;
      crash_cnt_q   <= '0;
      crash_latch_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      dist_q        <= dist_d;
      speed_q       <= speed_d;
      step_q        <= step_d;
      crash_cnt_q   <= crash_cnt_d;
      crash_latch_q <= crash_latch_d;
    end
  end

  assign distance_drove = dist_q;
  assign speed          = speed_q;
  assign race_state     = state_q;
  assign race_finished  = (state_q == FINISHED);

endmodule

// File: tb/tb_race_progress_tracker.sv
// Directed bench for race_progress_tracker: table of frame groups plus hand sequences for reset, idle hold and finish.
module tb_race_progress_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        accelerate = 1'b0;
  logic        brake = 1'b0;
  logic        crash = 1'b0;
  logic [31:0] distance_drove;
  logic [4:0]  speed;
  logic [1:0]  race_state;
  logic        race_finished;

  int errors = 0;
  int checks = 0;

  race_progress_tracker dut (
    .clk            (clk),
    .resetN         (rst),
    .frame_start    (frame_start),
    .accelerate     (accelerate),
    .brake          (brake),
    .crash          (crash),
    .distance_drove (distance_drove),
    .speed          (speed),
    .race_state     (race_state),
    .race_finished  (race_finished)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic        acc;
    logic        brk;
    logic        crash_before;
    logic [4:0]  exp_speed;
    logic [31:0] exp_dist;
    logic [1:0]  exp_state;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [4:0] sp, input logic [31:0] d,
                           input logic [1:0] st, input logic fin);
    check({name, ".speed"}, 32'(speed), 32'(sp));
    check({name, ".dist"}, distance_drove, d);
    check({name, ".state"}, 32'(race_state), 32'(st));
    check({name, ".finished"}, 32'(race_finished), 32'(fin));
  endtask

  // One frame: inputs and frame_start driven for exactly one rising edge, sampled on the next falling edge.
  task automatic do_frame(input logic a, input logic b, input logic c);
    @(negedge clk);
    accelerate  = a;
    brake       = b;
    crash       = c;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    crash       = 1'b0;
  endtask

  task automatic crash_pulse();
    @(negedge clk);
    crash = 1'b1;
    @(negedge clk);
    crash = 1'b0;
  endtask

  task automatic frames(input int n, input logic a, input logic b);
    for (int i = 0; i < n; i++) do_frame(a, b, 1'b0);
  endtask

  initial begin
    int changes;

    tbl[0]  = '{1,  1'b1, 1'b0, 1'b0, 5'd0,  32'd0,   2'd1};
    tbl[1]  = '{3,  1'b1, 1'b0, 1'b0, 5'd0,  32'd0,   2'd1};
    tbl[2]  = '{1,  1'b1, 1'b0, 1'b0, 5'd1,  32'd0,   2'd1};
    tbl[3]  = '{4,  1'b1, 1'b0, 1'b0, 5'd2,  32'd4,   2'd1};
    tbl[4]  = '{20, 1'b1, 1'b0, 1'b0, 5'd7,  32'd84,  2'd1};
    tbl[5]  = '{1,  1'b1, 1'b1, 1'b0, 5'd5,  32'd91,  2'd1};
    tbl[6]  = '{1,  1'b1, 1'b1, 1'b0, 5'd3,  32'd96,  2'd1};
    tbl[7]  = '{1,  1'b1, 1'b1, 1'b0, 5'd1,  32'd99,  2'd1};
    tbl[8]  = '{1,  1'b1, 1'b1, 1'b0, 5'd0,  32'd100, 2'd1};
    tbl[9]  = '{12, 1'b1, 1'b0, 1'b0, 5'd3,  32'd112, 2'd1};
    tbl[10] = '{3,  1'b0, 1'b0, 1'b0, 5'd3,  32'd121, 2'd1};
    tbl[11] = '{1,  1'b0, 1'b0, 1'b0, 5'd2,  32'd124, 2'd1};
    tbl[12] = '{4,  1'b0, 1'b0, 1'b0, 5'd1,  32'd132, 2'd1};
    tbl[13] = '{4,  1'b0, 1'b0, 1'b0, 5'd0,  32'd136, 2'd1};
    tbl[14] = '{4,  1'b0, 1'b0, 1'b0, 5'd0,  32'd136, 2'd1};
    tbl[15] = '{40, 1'b1, 1'b0, 1'b0, 5'd10, 32'd316, 2'd1};
    tbl[16] = '{1,  1'b1, 1'b0, 1'b1, 5'd0,  32'd326, 2'd2};
    tbl[17] = '{30, 1'b1, 1'b0, 1'b1, 5'd0,  32'd326, 2'd2};
    tbl[18] = '{29, 1'b1, 1'b0, 1'b0, 5'd0,  32'd326, 2'd2};
    tbl[19] = '{1,  1'b1, 1'b0, 1'b0, 5'd0,  32'd326, 2'd1};
    tbl[20] = '{4,  1'b1, 1'b0, 1'b0, 5'd1,  32'd326, 2'd1};

    repeat (3) @(negedge clk);
    check_all("reset", 5'd0, 32'd0, 2'd0, 1'b0);
    rst = 1'b0;

    frames(10, 1'b0, 1'b0);
    check_all("idle10", 5'd0, 32'd0, 2'd0, 1'b0);

    for (int v = 0; v < NV; v++) begin
      if (tbl[v].crash_before) crash_pulse();
      frames(tbl[v].n, tbl[v].acc, tbl[v].brk);
      check_all($sformatf("vec%0d", v), tbl[v].exp_speed, tbl[v].exp_dist, tbl[v].exp_state, 1'b0);
    end

    // No frame_start for 1000 cycles: pedals toggle, nothing may move.
    changes = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      accelerate = ~accelerate;
      brake      = (i % 3) == 0;
      if (speed !== 5'd1 || distance_drove !== 32'd326 || race_state !== 2'd1) changes++;
    end
    check("hold_changes", 32'(changes), 32'd0);
    check_all("hold_end", 5'd1, 32'd326, 2'd1, 1'b0);

    // Asynchronous reset mid-frame, observed before the next clock edge.
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all("async_rst", 5'd0, 32'd0, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Drive to exactly 10690 at speed 10, then finish on a crash+frame_start cycle.
    frames(65, 1'b1, 1'b0);
    check_all("top16", 5'd16, 32'd480, 2'd1, 1'b0);
    frames(634, 1'b1, 1'b0);
    check_all("cruise", 5'd16, 32'd10624, 2'd1, 1'b0);
    frames(2, 1'b0, 1'b1);
    frames(2, 1'b1, 1'b0);
    frames(1, 1'b0, 1'b1);
    check_all("pre_finish", 5'd10, 32'd10690, 2'd1, 1'b0);
    do_frame(1'b1, 1'b0, 1'b1);
    check_all("finish", 5'd0, 32'd10700, 2'd3, 1'b1);
    crash_pulse();
    frames(3, 1'b1, 1'b0);
    do_frame(1'b1, 1'b1, 1'b1);
    check_all("frozen", 5'd0, 32'd10700, 2'd3, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
